// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate block.
package mac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [3:0] ALUOP_SUM = 4'b0100;
   localparam logic [3:0] ALUOP_MUL = 4'b0110;

endpackage

// File: rtl/mac_datapath.sv
// Combinational MAC step: truncated signed product added to the accumulator,
// with overflow detection and optional saturation.
module mac_datapath
   import mac_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int SAT    = 0
) (
   input  logic [DATA_W-1:0] acc_i,
   input  logic [DATA_W-1:0] op1_i,
   input  logic [DATA_W-1:0] op2_i,
   output logic [DATA_W-1:0] acc_nxt_o,
   output logic              ovf_mul_o,
   output logic              ovf_add_o
);

   localparam int XW = 2 * DATA_W;

   localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   function automatic logic [XW-1:0] sext(input logic [DATA_W-1:0] v);
      return {{DATA_W{v[DATA_W-1]}}, v};
   endfunction

   // Both ops run at double width on sign-extended inputs, so the result is exact.
   function automatic logic [XW-1:0] alu(input logic [3:0] op,
                                         input logic [XW-1:0] a,
                                         input logic [XW-1:0] b);
      case (op)
         ALUOP_SUM: return a + b;
         ALUOP_MUL: return a * b;
         default:   return '0;
      endcase
   endfunction

   logic [XW-1:0]     prod;
   logic [XW-1:0]     sum;
   logic [DATA_W-1:0] pt;
   logic [DATA_W-1:0] sum_t;

   assign prod      = alu(ALUOP_MUL, sext(op1_i), sext(op2_i));
   assign pt        = prod[DATA_W-1:0];
   assign ovf_mul_o = (prod != sext(pt));

   assign sum       = alu(ALUOP_SUM, sext(acc_i), sext(pt));
   assign sum_t     = sum[DATA_W-1:0];
   assign ovf_add_o = (sum != sext(sum_t));

   // An add overflow implies both operands share acc's sign, so acc picks the rail.
   always_comb begin
      acc_nxt_o = sum_t;
      if (SAT != 0 && ovf_add_o)
         acc_nxt_o = acc_i[DATA_W-1] ? MIN_NEG : MAX_POS;
   end

endmodule

// File: rtl/mac_accum.sv
// Dot-product accumulator: bias plus LEN op1*op2 beats, result held until consumed.
module mac_accum
   import mac_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN    = 8,
   parameter int SAT    = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [DATA_W-1:0] bias,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] op1,
   input  logic [DATA_W-1:0] op2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic              ovf_mul,
   output logic              ovf_add,
   output logic              zero_result,
   output logic              busy
);

   localparam int               CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mul_q, mul_d;
   logic              add_q, add_d;

   logic [DATA_W-1:0] dp_acc;
   logic              dp_mul;
   logic              dp_add;

   mac_datapath #(
      .DATA_W (DATA_W),
      .SAT    (SAT)
   ) u_dp (
      .acc_i     (acc_q),
      .op1_i     (op1),
      .op2_i     (op2),
      .acc_nxt_o (dp_acc),
      .ovf_mul_o (dp_mul),
      .ovf_add_o (dp_add)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      mul_d   = mul_q;
      add_d   = add_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACCUM;
               acc_d   = bias;
               cnt_d   = '0;
               mul_d   = 1'b0;
               add_d   = 1'b0;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               acc_d = dp_acc;
               mul_d = mul_q | dp_mul;
               add_d = add_q | dp_add;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  res_d   = dp_acc;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         mul_q   <= 1'b0;
         add_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         mul_q   <= mul_d;
         add_q   <= add_d;
      end
   end

   assign in_ready    = (state_q == ST_ACCUM);
   assign out_valid   = (state_q == ST_DONE);
   assign busy        = (state_q != ST_IDLE);
   assign result      = res_q;
   assign ovf_mul     = mul_q;
   assign ovf_add     = add_q;
   // Qualified by DONE so an idle, freshly reset block does not report a zero result.
   assign zero_result = (state_q == ST_DONE) && (acc_q == '0);

endmodule
